alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
Parametrised multi-cycle ALU for the RISC-V 5-stage pipeline (EX stage).
- Keeps the existing single-cycle op set and opcode map (0x0-0x9).
- Adds variable shift amounts, SRA, SLTU and iterative MUL/MULHU/DIVU/REMU.
- Adds a valid/ready handshake on both sides, so hazard logic can stall the pipeline while an iterative op is in flight.

Parameters:
- XLEN, 32: operand/result width; must be a power of 2, at least 8.
- SHW, $clog2(XLEN): shift-amount width; derived, do not override.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous abort of any in-flight or held op.
- in_valid  in  1  operands and opcode valid.
- in_ready  out  1  block can accept; high only in IDLE.
- in1  in  XLEN  operand A.
- in2  in  XLEN  operand B; shift amount is in2[SHW-1:0].
- ctrl  in  4  opcode.
- out_valid  out  1  result/branch_taken valid.
- out_ready  in  1  consumer takes the result.
- ALU_out  out  XLEN  result.
- branch_taken  out  1  comparison outcome for branch ops.
- busy  out  1  high in BUSY.

Behaviour:
- Opcode map:
  - 0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND.
  - 5 SLL, 6 SRL: shift in1 by in2[SHW-1:0].
  - 7 BEQ, 8 BNE.
  - 9 SLT (signed), A SLTU, B SRA.
  - C MUL (low XLEN bits), D MULHU (high XLEN bits, unsigned).
  - E DIVU, F REMU.
- Add/sub wrap modulo 2^XLEN; no overflow flag.
- For branch ops, ALU_out=0. For all other ops, branch_taken=0.
- SLT/SLTU results are zero-extended 0 or 1.
- FSM states:
  - IDLE: in_ready=1. On in_valid (the accepting edge E0):
    - ops 0-B: register result, go to DONE.
    - ops C-F: latch operands, clear step counter, go to BUSY.
  - BUSY: one iteration per edge.
    - MUL/MULHU: shift-add, 2*XLEN-bit product.
    - DIVU/REMU: restoring division, one quotient bit per step.
    - After exactly XLEN steps (edges E1..E_XLEN), go to DONE.
  - DONE: out_valid=1; ALU_out and branch_taken held stable. On out_ready, go to IDLE.
- Latency: single-cycle ops have out_valid=1 in the cycle after acceptance. Iterative ops have out_valid=1 XLEN cycles later than that.
- A new op is never accepted in the cycle a result is consumed, because in_ready=0 in DONE. Back-to-back throughput is 1 op per 2 cycles.
- in1, in2 and ctrl are sampled only at E0. Changes afterwards have no effect.
- Divide by zero: DIVU returns all-ones; REMU returns in1. Still takes the full XLEN steps; no exception.
- MULHU: the upper XLEN bits of the unsigned 2*XLEN-bit product.
- flush: at the next edge go to IDLE, out_valid=0, step counter cleared, result discarded. Applies in any state and has priority over in_valid and out_ready.
- rst has priority over flush. Reset values:
  - state IDLE.
  - ALU_out=0, branch_taken=0, out_valid=0, busy=0, in_ready=1.
  - Internal accumulators and counter cleared.
- Reset mid-BUSY: nothing is emitted afterwards; the next op starts clean.
- out_ready while not in DONE is ignored.
- in_valid while not in IDLE is ignored. The producer holds its request until it sees in_ready.

Decomposition:
- Package alu_pkg:
  - opcode constants OP_ADD..OP_REMU (4-bit).
  - FSM state encoding (IDLE/BUSY/DONE).
  - helper function is_iter(ctrl).
- Sub-module alu_muldiv_iter (XLEN parameter):
  - Holds the iterative datapath: 2*XLEN accumulator, remainder/quotient registers, step counter.
  - Interface: start, op, a, b, done, result.
  - Single-cycle logic and the FSM stay in alu_mc.

Test Plan:
- Single-cycle ops, XLEN=32:
  - ADD 0xFFFFFFFF+1 gives ALU_out=0 one cycle after accept.
  - SRA 0x80000000 by 4 gives 0xF8000000.
  - SLT 0xFFFFFFFF,1 gives 1; SLTU with the same operands gives 0.
  - BNE 5,6 gives branch_taken=1, ALU_out=0.
- MUL 0x10000 * 0x10000: out_valid rises exactly 32 cycles after the single-cycle case, ALU_out=0. MULHU with the same operands gives 0x00000001.
- DIVU 100/7 gives 14; REMU gives 2. DIVU by 0 gives 0xFFFFFFFF; REMU 123 by 0 gives 123.
- Backpressure: hold out_ready=0 for 10 cycles in DONE. Outputs stay stable and in_ready=0. Raise out_ready: out_valid falls next cycle.
- flush in BUSY cycle 5 of a DIVU: out_valid never rises, in_ready=1 next cycle, and a following ADD 2+3 returns 5.
- rst asserted mid-MUL: all outputs return to reset values next cycle. Repeat with XLEN=8: MUL 15*17 gives 0xFF, latency 8 iterations.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU.
//   - 4-bit opcode constants OP_ADD..OP_REMU
//   - FSM state encoding (IDLE/BUSY/DONE)
//   - is_iter(): opcodes handled by the iterative mul/div datapath
package alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_XOR   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_AND   = 4'h4;
  localparam logic [3:0] OP_SLL   = 4'h5;
  localparam logic [3:0] OP_SRL   = 4'h6;
  localparam logic [3:0] OP_BEQ   = 4'h7;
  localparam logic [3:0] OP_BNE   = 4'h8;
  localparam logic [3:0] OP_SLT   = 4'h9;
  localparam logic [3:0] OP_SLTU  = 4'hA;
  localparam logic [3:0] OP_SRA   = 4'hB;
  localparam logic [3:0] OP_MUL   = 4'hC;
  localparam logic [3:0] OP_MULHU = 4'hD;
  localparam logic [3:0] OP_DIVU  = 4'hE;
  localparam logic [3:0] OP_REMU  = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Iterative ops occupy the whole 0xC-0xF quadrant.
  function automatic logic is_iter(input logic [3:0] ctrl);
    return ctrl[3:2] == 2'b11;
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative multiply / unsigned divide datapath, one step per clock.
//   clk, rst (sync, active-high), flush : clock and clears
//   start  : load operands and begin; op[1]=0 multiply, 1 divide;
//            op[0] selects the high half (MULHU / REMU) of acc
//   a, b   : operands, sampled only on start
//   done   : high during the cycle whose edge performs the last step
//   result : selected half of the accumulator, held after completion
module alu_muldiv_iter
  #(parameter int XLEN = 32)
  (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result
  );

  localparam int CW = $clog2(XLEN);

  // Multiply: acc = {partial product, remaining multiplier bits}.
  // Divide:   acc = {remainder, dividend bits shifting out / quotient bits shifting in}.
  logic [2*XLEN-1:0] acc_q, acc_step;
  logic [XLEN-1:0]   m_q;           // multiplicand or divisor
  logic [1:0]        op_q;
  logic [CW-1:0]     cnt_q;
  logic              active_q;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     r_shift;
  logic [XLEN-1:0]   diff;
  logic              ge;

  always_comb begin
    // Shift-add: add multiplicand into the high half when the current
    // multiplier bit is set, then shift the whole product right, keeping the carry.
    mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? m_q : {XLEN{1'b0}})};
    // Restoring division: bring the next dividend bit into the remainder.
    // A zero divisor always "fits", giving all-ones quotient and remainder = dividend.
    r_shift  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    ge       = r_shift >= {1'b0, m_q};
    diff     = r_shift[XLEN-1:0] - m_q;
    if (op_q[1]) acc_step = {(ge ? diff : r_shift[XLEN-1:0]), acc_q[XLEN-2:0], ge};
    else         acc_step = {mul_sum, acc_q[XLEN-1:1]};
  end

  // XLEN is a power of two, so the final step is the all-ones count.
  assign done   = active_q & (&cnt_q);
  assign result = op_q[0] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous: it is only an ordinary input sampled on the clock edge.
    if (rst || flush) begin
      acc_q    <= '0;
      m_q      <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (start) begin
      acc_q    <= {{XLEN{1'b0}}, (op[1] ? a : b)};
      m_q      <= op[1] ? b : a;
      op_q     <= op;
      cnt_q    <= '0;
      active_q <= 1'b1;
    end else if (active_q) begin
      acc_q <= acc_step;
      cnt_q <= cnt_q + CW'(1);
      if (done) active_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU for the EX stage with valid/ready handshakes.
//   clk, rst (sync, active-high), flush (sync abort)
//   in_valid/in_ready  : request handshake; in_ready only in IDLE
//   in1, in2, ctrl     : operands and opcode, sampled at acceptance
//   out_valid/out_ready: result handshake; out_valid only in DONE
//   ALU_out, branch_taken : result, held stable while in DONE
//   busy               : iterative op in flight
module alu_mc
  import alu_pkg::*;
  #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
  )
  (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    input  logic [3:0]      ctrl,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] ALU_out,
    output logic            branch_taken,
    output logic            busy
  );

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            br_q, br_d;
  logic            iter_q, iter_d;   // result comes from the iterative datapath
  logic            start;
  logic            md_done;
  logic [XLEN-1:0] md_result;

  logic [XLEN-1:0] sc_res;
  logic            sc_br;
  logic [SHW-1:0]  shamt;

  assign shamt = in2[SHW-1:0];

  // Single-cycle datapath.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    sc_res = '0;
    sc_br  = 1'b0;
    unique case (ctrl)
      OP_ADD:  sc_res = in1 + in2;
      OP_SUB:  sc_res = in1 - in2;
      OP_XOR:  sc_res = in1 ^ in2;
      OP_OR:   sc_res = in1 | in2;
      OP_AND:  sc_res = in1 & in2;
      OP_SLL:  sc_res = in1 << shamt;
      OP_SRL:  sc_res = in1 >> shamt;
      OP_BEQ:  sc_br  = in1 == in2;
      OP_BNE:  sc_br  = in1 != in2;
      OP_SLT:  sc_res[0] = $signed(in1) < $signed(in2);
      OP_SLTU: sc_res[0] = in1 < in2;
      OP_SRA:  sc_res = $signed(in1) >>> shamt;
      default: ;
    endcase
  end

  alu_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .start  (start),
    .op     (ctrl[1:0]),
    .a      (in1),
    .b      (in2),
    .done   (md_done),
    .result (md_result)
  );

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    br_d     = br_q;
    iter_d   = iter_q;
    start    = 1'b0;
    unique case (state_q)
      S_IDLE: if (in_valid) begin
        if (is_iter(ctrl)) begin
          start    = 1'b1;
          iter_d   = 1'b1;
          result_d = '0;
          br_d     = 1'b0;
          state_d  = S_BUSY;
        end else begin
          iter_d   = 1'b0;
          result_d = sc_res;
          br_d     = sc_br;
          state_d  = S_DONE;
        end
      end
      S_BUSY:  if (md_done) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Flush overrides any accept or consume in the same cycle.
    if (flush) begin
      state_d  = S_IDLE;
      start    = 1'b0;
      iter_d   = 1'b0;
      result_d = '0;
      br_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      br_q     <= 1'b0;
      iter_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      br_q     <= br_d;
      iter_q   <= iter_d;
    end
  end

  assign in_ready     = state_q == S_IDLE;
  assign out_valid    = state_q == S_DONE;
  assign busy         = state_q == S_BUSY;
  assign ALU_out      = iter_q ? md_result : result_q;
  assign branch_taken = br_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc: one XLEN=32 and one XLEN=8 instance.
module tb_alu_mc;
  import alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush;
  logic [31:0] in1, in2;
  logic [3:0]  ctrl;

  logic        iv32, ir32, ov32, or32, br32, busy32;
  logic [31:0] out32;
  logic        iv8, ir8, ov8, or8, br8, busy8;
  logic [7:0]  out8;

  alu_mc #(.XLEN(32)) dut32 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(iv32), .in_ready(ir32),
    .in1(in1), .in2(in2), .ctrl(ctrl),
    .out_valid(ov32), .out_ready(or32),
    .ALU_out(out32), .branch_taken(br32), .busy(busy32)
  );

  alu_mc #(.XLEN(8)) dut8 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(iv8), .in_ready(ir8),
    .in1(in1[7:0]), .in2(in2[7:0]), .ctrl(ctrl),
    .out_valid(ov8), .out_ready(or8),
    .ALU_out(out8), .branch_taken(br8), .busy(busy8)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Output views of the selected instance (s=1 -> XLEN=8).
  function automatic logic        cur_ov(input bit s);   return s ? ov8   : ov32;   endfunction
  function automatic logic        cur_ir(input bit s);   return s ? ir8   : ir32;   endfunction
  function automatic logic        cur_br(input bit s);   return s ? br8   : br32;   endfunction
  function automatic logic        cur_busy(input bit s); return s ? busy8 : busy32; endfunction
  function automatic logic [31:0] cur_out(input bit s);  return s ? {24'b0, out8} : out32; endfunction

  // Issue one op, scramble the operand bus after acceptance, and wait for
  // out_valid. Latency counts edges from acceptance to out_valid visible.
  // Leaves the DUT in DONE with out_ready low.
  task automatic run_op(input bit s, input string tag, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic exp_br, input int exp_lat);
    int lat;
    @(negedge clk);
    check({tag, ":in_ready"}, 32'(cur_ir(s)), 32'd1);
    in1 = a; in2 = b; ctrl = op;
    if (s) iv8 = 1'b1; else iv32 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv8 = 1'b0; iv32 = 1'b0;
    in1 = ~a; in2 = ~b; ctrl = ~op;
    lat = 1;
    while (!cur_ov(s) && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ":latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ":result"}, cur_out(s), exp_res);
    check({tag, ":branch"}, 32'(cur_br(s)), 32'(exp_br));
  endtask

  task automatic consume(input bit s, input string tag);
    if (s) or8 = 1'b1; else or32 = 1'b1;
    @(negedge clk);
    or8 = 1'b0; or32 = 1'b0;
    check({tag, ":consumed"}, 32'({cur_ov(s), cur_ir(s)}), 32'b01);
  endtask

  task automatic op_and_consume(input bit s, input string tag, input logic [3:0] op,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] exp_res, input logic exp_br, input int exp_lat);
    run_op(s, tag, op, a, b, exp_res, exp_br, exp_lat);
    consume(s, tag);
  endtask

  task automatic check_reset_outputs(input bit s, input string tag);
    check({tag, ":ALU_out"}, cur_out(s), 32'd0);
    check({tag, ":flags"}, 32'({cur_br(s), cur_ov(s), cur_busy(s), cur_ir(s)}), 32'b0001);
  endtask

  // Start an iterative op, reset partway through, and verify nothing emerges.
  task automatic reset_mid_op(input bit s, input string tag, input int cycles);
    bit seen;
    @(negedge clk);
    in1 = 32'h0000_00AB; in2 = 32'h0000_00CD; ctrl = OP_MUL;
    if (s) iv8 = 1'b1; else iv32 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv8 = 1'b0; iv32 = 1'b0;
    repeat (cycles) @(negedge clk);
    check({tag, ":busy_before"}, 32'(cur_busy(s)), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs(s, tag);
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (cur_ov(s)) seen = 1'b1;
    end
    check({tag, ":no_output"}, 32'(seen), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst = 1'b1; flush = 1'b0;
    in1 = '0; in2 = '0; ctrl = '0;
    iv32 = 1'b0; or32 = 1'b0; iv8 = 1'b0; or8 = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs(1'b0, "reset32");
    check_reset_outputs(1'b1, "reset8");
    rst = 1'b0;

    // Single-cycle ops.
    op_and_consume(0, "add_wrap", OP_ADD,  32'hFFFF_FFFF, 32'h1,  32'h0,         1'b0, 1);
    op_and_consume(0, "sub",      OP_SUB,  32'd3,         32'd5,  32'hFFFF_FFFE, 1'b0, 1);
    op_and_consume(0, "xor",      OP_XOR,  32'hF0F0_1234, 32'hFF00_FFFF, 32'h0FF0_EDCB, 1'b0, 1);
    op_and_consume(0, "sll",      OP_SLL,  32'h1,         32'd31, 32'h8000_0000, 1'b0, 1);
    op_and_consume(0, "srl",      OP_SRL,  32'h8000_0000, 32'd31, 32'h1,         1'b0, 1);
    // Only in2[4:0] is the shift amount: 0x24 shifts by 4.
    op_and_consume(0, "sra",      OP_SRA,  32'h8000_0000, 32'h24, 32'hF800_0000, 1'b0, 1);
    op_and_consume(0, "slt",      OP_SLT,  32'hFFFF_FFFF, 32'd1,  32'd1,         1'b0, 1);
    op_and_consume(0, "sltu",     OP_SLTU, 32'hFFFF_FFFF, 32'd1,  32'd0,         1'b0, 1);
    op_and_consume(0, "bne",      OP_BNE,  32'd5,         32'd6,  32'd0,         1'b1, 1);
    op_and_consume(0, "beq_ne",   OP_BEQ,  32'd5,         32'd6,  32'd0,         1'b0, 1);

    // Iterative ops: 32 extra cycles.
    op_and_consume(0, "mul",      OP_MUL,   32'h0001_0000, 32'h0001_0000, 32'h0,          1'b0, 33);
    op_and_consume(0, "mulhu",    OP_MULHU, 32'h0001_0000, 32'h0001_0000, 32'h1,          1'b0, 33);
    op_and_consume(0, "mulhu_max",OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE,  1'b0, 33);
    op_and_consume(0, "mul_max",  OP_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,          1'b0, 33);
    op_and_consume(0, "divu",     OP_DIVU,  32'd100, 32'd7, 32'd14,        1'b0, 33);
    op_and_consume(0, "remu",     OP_REMU,  32'd100, 32'd7, 32'd2,         1'b0, 33);
    op_and_consume(0, "divu_z",   OP_DIVU,  32'd5,   32'd0, 32'hFFFF_FFFF, 1'b0, 33);
    op_and_consume(0, "remu_z",   OP_REMU,  32'd123, 32'd0, 32'd123,       1'b0, 33);

    // Backpressure: result held for 10 cycles, in_valid ignored meanwhile.
    run_op(0, "bp", OP_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1);
    in1 = 32'd7; in2 = 32'd7; ctrl = OP_SUB; iv32 = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (!ov32 || ir32 || out32 !== 32'd5 || br32) seen = 1'b1;
    end
    iv32 = 1'b0;
    check("bp:stable", 32'(seen), 32'd0);
    consume(0, "bp");

    // Flush during BUSY cycle 5 of a DIVU.
    @(negedge clk);
    in1 = 32'd100; in2 = 32'd7; ctrl = OP_DIVU; iv32 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv32 = 1'b0;
    repeat (4) @(negedge clk);
    check("flush:busy_before", 32'(busy32), 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush:idle", 32'({ov32, busy32, ir32}), 32'b001);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ov32) seen = 1'b1;
    end
    check("flush:no_output", 32'(seen), 32'd0);
    op_and_consume(0, "post_flush_add", OP_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1);

    // Reset in the middle of a multiply, then a clean op.
    reset_mid_op(0, "rst_mid32", 10);
    op_and_consume(0, "post_rst_mul", OP_MUL, 32'd6, 32'd7, 32'd42, 1'b0, 33);

    // XLEN=8 instance: 8 iterations.
    reset_mid_op(1, "rst_mid8", 3);
    op_and_consume(1, "mul8",    OP_MUL,   32'd15,  32'd17, 32'hFF, 1'b0, 9);
    op_and_consume(1, "mulhu8",  OP_MULHU, 32'd15,  32'd17, 32'h00, 1'b0, 9);
    op_and_consume(1, "divu8",   OP_DIVU,  32'd255, 32'd16, 32'd15, 1'b0, 9);
    op_and_consume(1, "remu8",   OP_REMU,  32'd200, 32'd16, 32'd8,  1'b0, 9);
    op_and_consume(1, "add8",    OP_ADD,   32'hFF,  32'h01, 32'h00, 1'b0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
